ctl_shot: RTL and testbench

Shot-control stage between the mouse input and the score/ammo displays. It turns left-button presses into discrete shots and tests each shot against the current duck bounding box. It produces a one-cycle `hit` pulse for the score counter and keeps the remaining ammunition as two BCD digits for the hex display multiplexer. It runs in the 65 MHz pixel-clock domain alongside the duck controller.

---
 rtl/ctl_shot.sv | 162 ++++++++++++++++
 tb/tb_ctl_shot.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_shot.sv
// Shot controller: turns left-button presses into rate-limited shots, tests each
// shot against the duck hitbox and tracks the remaining ammunition in BCD.
module ctl_shot #(
  parameter int AMMO_START      = 10,
  parameter int DUCK_W          = 64,
  parameter int DUCK_H          = 64,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic [10:0] duck_x,
  input  logic [10:0] duck_y,
  input  logic        duck_show,
  input  logic        reload,
  output logic        shot,
  output logic        hit,
  output logic [3:0]  ammo_tens,
  output logic [3:0]  ammo_ones,
  output logic        empty,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_EVAL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_EMPTY = 2'd3
  } state_e;

  localparam logic [3:0]  TENS_INIT = 4'(AMMO_START / 10);
  localparam logic [3:0]  ONES_INIT = 4'(AMMO_START % 10);
  localparam logic [7:0]  CD_MAX    = 8'(COOLDOWN_FRAMES);
  localparam logic [12:0] BOX_W     = 13'(DUCK_W);
  localparam logic [12:0] BOX_H     = 13'(DUCK_H);

  state_e      state_q, state_d;
  logic        btn_d_q, btn_d_d;
  logic [11:0] mx_q, mx_d;
  logic [11:0] my_q, my_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        shot_q, shot_d;
  logic        hit_q, hit_d;
  logic        empty_q, empty_d;

  logic        press;
  logic        ammo_zero;
  logic [12:0] mx_ext, my_ext;
  logic [12:0] box_x0, box_y0, box_x1, box_y1;
  logic        in_box;

  assign press     = mouse_left & ~btn_d_q;
  assign ammo_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // 13-bit arithmetic so a duck near the right/bottom edge cannot wrap its box.
  assign mx_ext = {1'b0, mx_q};
  assign my_ext = {1'b0, my_q};
  assign box_x0 = {2'b00, duck_x};
  assign box_y0 = {2'b00, duck_y};
  assign box_x1 = box_x0 + BOX_W;
  assign box_y1 = box_y0 + BOX_H;
  assign in_box = duck_show
                  && (mx_ext >= box_x0) && (mx_ext < box_x1)
                  && (my_ext >= box_y0) && (my_ext < box_y1);

  always_comb begin
    state_d = state_q;
    btn_d_d = mouse_left;
    mx_d    = mx_q;
    my_d    = my_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    shot_d  = 1'b0;
    hit_d   = 1'b0;

    if (reload) begin
      state_d = ST_ARMED;
      cnt_d   = 8'd0;
      tens_d  = TENS_INIT;
      ones_d  = ONES_INIT;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (press) begin
            mx_d    = mouse_x;
            my_d    = mouse_y;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          shot_d = 1'b1;
          hit_d  = in_box;
          cnt_d  = 8'd0;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (new_frame && (cnt_q != CD_MAX)) begin
            cnt_d = cnt_q + 8'd1;
          end
          // Re-arm only once the cooldown has elapsed and the button is up.
          if ((cnt_q == CD_MAX) && !mouse_left) begin
            state_d = ammo_zero ? ST_EMPTY : ST_ARMED;
          end
        end
        ST_EMPTY: begin
          state_d = ST_EMPTY;
        end
        default: begin
          state_d = ST_ARMED;
        end
      endcase
    end

    empty_d = (state_d == ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ARMED;
      btn_d_q <= 1'b1;
      mx_q    <= 12'd0;
      my_q    <= 12'd0;
      cnt_q   <= 8'd0;
      tens_q  <= TENS_INIT;
      ones_q  <= ONES_INIT;
      shot_q  <= 1'b0;
      hit_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_d_q <= btn_d_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      shot_q  <= shot_d;
      hit_q   <= hit_d;
      empty_q <= empty_d;
    end
  end

  assign shot      = shot_q;
  assign hit       = hit_q;
  assign ammo_tens = tens_q;
  assign ammo_ones = ones_q;
  assign empty     = empty_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ctl_shot.sv
// Bench for ctl_shot: directed vector table, hand-written cooldown/empty/reset
// sequences, then random presses checked against an arithmetic model.
module tb_ctl_shot;

  localparam int AMMO_START = 10;
  localparam int CD         = 8;
  localparam int DW         = 64;
  localparam int DH         = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_frame;
  logic        mouse_left;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic [10:0] duck_x;
  logic [10:0] duck_y;
  logic        duck_show;
  logic        reload;
  logic        shot;
  logic        hit;
  logic [3:0]  ammo_tens;
  logic [3:0]  ammo_ones;
  logic        empty;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int model_ammo;
  int model_frames;

  typedef struct {
    logic [11:0] mx;
    logic [11:0] my;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        show;
    logic        exp_shot;
    logic        exp_hit;
    logic [7:0]  exp_ammo;
  } vec_t;

  vec_t vec[8];

  ctl_shot #(
    .AMMO_START(AMMO_START), .DUCK_W(DW), .DUCK_H(DH), .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .mouse_left(mouse_left),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .duck_x(duck_x), .duck_y(duck_y),
    .duck_show(duck_show), .reload(reload), .shot(shot), .hit(hit),
    .ammo_tens(ammo_tens), .ammo_ones(ammo_ones), .empty(empty),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int a);
    return 8'(((a / 10) * 16) + (a % 10));
  endfunction

  function automatic bit model_hit(input int mx, my, dx, dy, input bit show);
    return show && (mx >= dx) && (mx < dx + DW) && (my >= dy) && (my < dy + DH);
  endfunction

  task automatic check_ammo(input string name, input int a);
    check(name, {24'd0, ammo_tens, ammo_ones}, {24'd0, bcd(a)});
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_frames(input int n);
    repeat (n) begin
      new_frame = 1'b1;
      step();
      new_frame = 1'b0;
      step();
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic set_duck(input int dx, dy, input bit show);
    duck_x    = 11'(dx);
    duck_y    = 11'(dy);
    duck_show = show;
  endtask

  // Press at cycle N; shot/hit must be high during N+2 only.
  task automatic do_press(input int mx, my, input bit exp_s, exp_h, input string name);
    mouse_x    = 12'(mx);
    mouse_y    = 12'(my);
    mouse_left = 1'b1;
    step();
    check({name, "_shot_n1"}, {31'd0, shot}, 32'd0);
    step();
    check({name, "_shot"}, {31'd0, shot}, {31'd0, exp_s});
    check({name, "_hit"}, {31'd0, hit}, {31'd0, exp_h});
    step();
    check({name, "_shot_n3"}, {31'd0, shot}, 32'd0);
    mouse_left = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    new_frame  = 1'b0;
    mouse_left = 1'b1;
    mouse_x    = 12'd0;
    mouse_y    = 12'd0;
    duck_x     = 11'd0;
    duck_y     = 11'd0;
    duck_show  = 1'b0;
    reload     = 1'b0;

    vec[0] = '{12'd163,  12'd263,  11'd100,  11'd200,  1'b1, 1'b1, 1'b1, 8'h09};
    vec[1] = '{12'd164,  12'd200,  11'd100,  11'd200,  1'b1, 1'b1, 1'b0, 8'h08};
    vec[2] = '{12'd120,  12'd220,  11'd100,  11'd200,  1'b0, 1'b1, 1'b0, 8'h07};
    vec[3] = '{12'd100,  12'd200,  11'd100,  11'd200,  1'b1, 1'b1, 1'b1, 8'h06};
    vec[4] = '{12'd99,   12'd230,  11'd100,  11'd200,  1'b1, 1'b1, 1'b0, 8'h05};
    vec[5] = '{12'd130,  12'd264,  11'd100,  11'd200,  1'b1, 1'b1, 1'b0, 8'h04};
    vec[6] = '{12'd2100, 12'd2100, 11'd2047, 11'd2047, 1'b1, 1'b1, 1'b1, 8'h03};
    vec[7] = '{12'd4095, 12'd2100, 11'd2047, 11'd2047, 1'b1, 1'b1, 1'b0, 8'h02};

    // Button held through reset release must not fire.
    idle(3);
    rst = 1'b1;
    idle(4);
    check("rst_shot", {31'd0, shot}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd0);
    check("rst_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h10);
    mouse_left = 1'b0;
    idle(2);

    // Directed vector table, full cooldown between shots.
    for (int i = 0; i < 8; i++) begin
      set_duck(int'(vec[i].dx), int'(vec[i].dy), vec[i].show);
      do_press(int'(vec[i].mx), int'(vec[i].my), vec[i].exp_shot, vec[i].exp_hit,
               $sformatf("vec%0d", i));
      check($sformatf("vec%0d_ammo", i), {24'd0, ammo_tens, ammo_ones}, {24'd0, vec[i].exp_ammo});
      wait_frames(CD);
      idle(2);
    end

    pulse_reload();
    check("reload1_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h10);

    // Cooldown boundary: 3 and 7 frames are too early, 8 re-arms.
    set_duck(100, 200, 1'b1);
    do_press(163, 263, 1'b1, 1'b1, "cd_first");
    wait_frames(3);
    idle(2);
    do_press(163, 263, 1'b0, 1'b0, "cd_3frames");
    wait_frames(4);
    idle(2);
    do_press(163, 263, 1'b0, 1'b0, "cd_7frames");
    wait_frames(1);
    idle(2);
    do_press(163, 263, 1'b1, 1'b1, "cd_8frames");
    check("cd_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h08);

    pulse_reload();
    idle(1);

    // Ten shots to empty, then a dropped eleventh press.
    for (int i = 0; i < 10; i++) begin
      do_press(164, 200, 1'b1, 1'b0, $sformatf("drain%0d", i));
      check_ammo($sformatf("drain%0d_ammo", i), 9 - i);
      check($sformatf("drain%0d_empty", i), {31'd0, empty}, 32'd0);
      wait_frames(CD);
      idle(2);
    end
    check("empty_set", {31'd0, empty}, 32'd1);
    do_press(163, 263, 1'b0, 1'b0, "eleventh");
    check("eleventh_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h00);
    pulse_reload();
    check("reload2_empty", {31'd0, empty}, 32'd0);
    check("reload2_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h10);
    idle(2);

    // Reload wins over a simultaneous press.
    mouse_left = 1'b1;
    reload     = 1'b1;
    step();
    reload = 1'b0;
    check("rp_shot0", {31'd0, shot}, 32'd0);
    step();
    check("rp_shot1", {31'd0, shot}, 32'd0);
    step();
    check("rp_shot2", {31'd0, shot}, 32'd0);
    check("rp_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h10);
    mouse_left = 1'b0;
    idle(2);

    // Asynchronous reset while shot is high (entering HOLD).
    mouse_x    = 12'd163;
    mouse_y    = 12'd263;
    mouse_left = 1'b1;
    idle(2);
    check("ar_shot_pre", {31'd0, shot}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_shot", {31'd0, shot}, 32'd0);
    check("ar_hit", {31'd0, hit}, 32'd0);
    check("ar_empty", {31'd0, empty}, 32'd0);
    check("ar_ammo", {24'd0, ammo_tens, ammo_ones}, 32'h10);
    step();
    mouse_left = 1'b0;
    rst        = 1'b1;
    idle(2);

    // Randomized phase against the reference model.
    model_ammo   = AMMO_START;
    model_frames = 1000;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_reload();
        model_ammo   = AMMO_START;
        model_frames = 1000;
        check($sformatf("rnd%0d_rl_empty", it), {31'd0, empty}, 32'd0);
        check_ammo($sformatf("rnd%0d_rl_ammo", it), model_ammo);
        idle(1);
      end else begin
        int nf, dx, dy, mx, my;
        bit show, exp_s, exp_h;
        nf = int'($urandom_range(0, 10));
        wait_frames(nf);
        model_frames += nf;
        idle(2);
        check($sformatf("rnd%0d_empty", it), {31'd0, empty},
              {31'd0, (model_ammo == 0) && (model_frames >= CD)});
        dx   = int'($urandom_range(0, 2047));
        dy   = int'($urandom_range(0, 2047));
        show = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          mx = dx + int'($urandom_range(0, 80)) - 8;
          my = dy + int'($urandom_range(0, 80)) - 8;
          if (mx < 0) mx = 0;
          if (my < 0) my = 0;
        end else begin
          mx = int'($urandom_range(0, 4095));
          my = int'($urandom_range(0, 4095));
        end
        set_duck(dx, dy, show);
        exp_s = (model_ammo > 0) && (model_frames >= CD);
        exp_h = exp_s && model_hit(mx, my, dx, dy, show);
        do_press(mx, my, exp_s, exp_h, $sformatf("rnd%0d", it));
        if (exp_s) begin
          model_ammo--;
          model_frames = 0;
        end
        check_ammo($sformatf("rnd%0d_ammo", it), model_ammo);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
